// File: rtl/alu_serial_seq.sv
// -----------------------------------------------------------------------------
// alu_serial_seq
// Bit-serial sequencer for a single-bit ALU slice. Two WIDTH-bit operands are
// shifted LSB-first through one external slice, one bit per clock. The slice
// carry is chained through a register, and the WIDTH-bit result is assembled
// by shifting each slice output in at the MSB end.
//
// Optional feature macro: ALU_SERIAL_ZERO_EN
//   defined   -> zero flag (result == 0) is tracked through an nz register
//   undefined -> zero port is present but tied to 0
//
// Ports:
//   clk          rising-edge system clock
//   rst_n        asynchronous active-low reset
//   start        request pulse, sampled only in IDLE
//   op[1:0]      slice function code (00 add, 01 OR, 10 AND, 11 misc)
//   a, b         WIDTH-bit operands, latched on an accepted start
//   cin          initial carry / b-invert control, latched on an accepted start
//   busy         high while bits are being processed (RUN)
//   done         one-cycle pulse when result/cout are valid
//   result       assembled result, held until the next accepted start
//   cout         final carry, held with result
//   zero         result-is-zero flag (see macro above)
//   slice_a/b    current operand bits to the slice
//   slice_cin    current carry-in to the slice
//   slice_ctrl   function code to the slice
//   slice_f      slice function output (combinational)
//   slice_cout   slice carry output
// -----------------------------------------------------------------------------
module alu_serial_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             zero,
  output logic             slice_a,
  output logic             slice_b,
  output logic             slice_cin,
  output logic [1:0]       slice_ctrl,
  input  logic             slice_f,
  input  logic             slice_cout
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;

  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [1:0]       r_op_q;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_result;
  logic             r_cout;

  logic             w_accept;
  logic             w_last;

  assign w_accept = (r_state == IDLE) && start;
  assign w_last   = (r_state == RUN) && (r_cnt == LAST_BIT);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and state-decoded outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    busy         = 1'b0;
    done         = 1'b0;
    slice_a      = 1'b0;
    slice_b      = 1'b0;
    slice_cin    = 1'b0;
    slice_ctrl   = r_op_q;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_next = RUN;
        end
      end
      RUN: begin
        busy      = 1'b1;
        slice_a   = r_a_sh[0];
        slice_b   = r_b_sh[0];
        slice_cin = r_carry;
        if (r_cnt == LAST_BIT) begin
          w_state_next = DONE;
        end
      end
      DONE: begin
        done         = 1'b1;
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_op_q   <= 2'b00;
      r_carry  <= 1'b0;
      r_cnt    <= '0;
      r_result <= '0;
      r_cout   <= 1'b0;
    end else if (w_accept) begin
      r_a_sh   <= a;
      r_b_sh   <= b;
      r_op_q   <= op;
      r_carry  <= cin;
      r_cnt    <= '0;
      r_result <= '0;
    end else if (r_state == RUN) begin
      r_a_sh   <= {1'b0, r_a_sh[WIDTH-1:1]};
      r_b_sh   <= {1'b0, r_b_sh[WIDTH-1:1]};
      r_carry  <= slice_cout;
      r_cnt    <= r_cnt + 1'b1;
      r_result <= {slice_f, r_result[WIDTH-1:1]};
      // cout is captured together with the final carry so it is already
      // valid during the DONE cycle and then simply held.
      if (w_last) begin
        r_cout <= slice_cout;
      end
    end
  end

  assign result = r_result;
  assign cout   = r_cout;

`ifdef ALU_SERIAL_ZERO_EN
  logic r_nz;
  logic r_zero;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_nz   <= 1'b0;
      r_zero <= 1'b0;
    end else if (w_accept) begin
      r_nz <= 1'b0;
    end else if (r_state == RUN) begin
      r_nz <= r_nz | slice_f;
      // Include the final bit directly so zero is valid alongside done.
      if (w_last) begin
        r_zero <= ~(r_nz | slice_f);
      end
    end
  end

  assign zero = r_zero;
`else
  assign zero = 1'b0;
`endif

endmodule

// File: tb/tb_alu_serial_seq.sv
// -----------------------------------------------------------------------------
// tb_alu_serial_seq
// Directed-vector bench with a scoreboard: each issued operation pushes its
// hand-computed result into a queue; a monitor pops and compares on done.
// A behavioural single-bit slice is attached to the slice_* ports.
// -----------------------------------------------------------------------------
module tb_alu_serial_seq;

  localparam int WIDTH = 8;

`ifdef ALU_SERIAL_ZERO_EN
  localparam bit ZERO_ON = 1'b1;
`else
  localparam bit ZERO_ON = 1'b0;
`endif

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             zero;
  logic             slice_a;
  logic             slice_b;
  logic             slice_cin;
  logic [1:0]       slice_ctrl;
  logic             slice_f;
  logic             slice_cout;

  alu_serial_seq #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .op         (op),
    .a          (a),
    .b          (b),
    .cin        (cin),
    .busy       (busy),
    .done       (done),
    .result     (result),
    .cout       (cout),
    .zero       (zero),
    .slice_a    (slice_a),
    .slice_b    (slice_b),
    .slice_cin  (slice_cin),
    .slice_ctrl (slice_ctrl),
    .slice_f    (slice_f),
    .slice_cout (slice_cout)
  );

  // Behavioural slice: add = full adder; logic ops use cin to invert b and
  // pass cin straight through to cout.
  always_comb begin
    slice_f    = 1'b0;
    slice_cout = slice_cin;
    case (slice_ctrl)
      2'b00: begin
        slice_f    = slice_a ^ slice_b ^ slice_cin;
        slice_cout = (slice_a & slice_b) | (slice_a & slice_cin) | (slice_b & slice_cin);
      end
      2'b01:   slice_f = slice_a | (slice_b ^ slice_cin);
      2'b10:   slice_f = slice_a & (slice_b ^ slice_cin);
      default: slice_f = slice_a ^ slice_b ^ slice_cin;
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [WIDTH-1:0] r;
    logic             c;
    logic             z;
  } exp_t;

  exp_t sb[$];

  int n_checks;
  int n_fail;
  int n_done;
  int n_expect;
  logic last_cout;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares on every done pulse, and checks the busy run length.
  initial begin
    int   run_len;
    exp_t e;
    run_len = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        run_len = 0;
      end else begin
        if (busy) run_len++;
        if (done) begin
          n_done++;
          chk("busy_len", run_len, WIDTH);
          run_len = 0;
          if (sb.size() == 0) begin
            chk("unexpected_done", 1, 0);
          end else begin
            e = sb.pop_front();
            chk("result", result, e.r);
            chk("cout", cout, e.c);
            chk("zero", zero, e.z);
            $display("op done: result=0x%02h cout=%0d zero=%0d (exp 0x%02h %0d %0d)",
                     result, cout, zero, e.r, e.c, e.z);
          end
        end
      end
    end
  end

  task automatic run_op(input logic [1:0] o, input logic [WIDTH-1:0] xa, input logic [WIDTH-1:0] xb,
                        input logic xc, input logic [WIDTH-1:0] er, input logic ec, input bit poke);
    exp_t e;
    int   k;
    bit   got;
    e.r = er;
    e.c = ec;
    e.z = ZERO_ON ? (er == '0) : 1'b0;
    sb.push_back(e);
    n_expect++;
    @(negedge clk);
    op = o; a = xa; b = xb; cin = xc; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = WIDTH'($urandom);
    b = WIDTH'($urandom);
    cin = 1'($urandom);
    chk("start_result_clear", result, 0);
    chk("start_cout_held", cout, last_cout);
    chk("start_busy", busy, 1);
    chk("start_slice_a", slice_a, xa[0]);
    chk("start_slice_ctrl", slice_ctrl, o);
    got = 1'b0;
    for (k = 1; k <= 20; k++) begin
      if (done) begin
        got = 1'b1;
        break;
      end
      if (poke && k == 3) begin
        start = 1'b1;
        op = 2'b11;
        a = WIDTH'($urandom);
      end
      if (poke && k == 4) start = 1'b0;
      @(negedge clk);
    end
    if (!got) begin
      chk("done_timeout", 0, 1);
    end else begin
      chk("done_latency", k, WIDTH + 1);
    end
    if (poke) begin
      // start high across the DONE->IDLE edge must be ignored
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("poke_not_accepted", busy, 0);
    end else begin
      @(negedge clk);
    end
    chk("idle_result_held", result, er);
    chk("idle_cout_held", cout, ec);
    last_cout = ec;
  endtask

  initial begin
    n_checks = 0; n_fail = 0; n_done = 0; n_expect = 0;
    last_cout = 1'b0;
    rst_n = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0; cin = 1'b0;
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    chk("rst_cout", cout, 0);
    chk("rst_zero", zero, 0);
    chk("rst_slice", {slice_a, slice_b, slice_cin, slice_ctrl}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(2'b00, 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b0);
    run_op(2'b00, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    run_op(2'b01, 8'hA0, 8'h0F, 1'b0, 8'hAF, 1'b0, 1'b0);
    run_op(2'b10, 8'hF0, 8'h30, 1'b1, 8'hC0, 1'b1, 1'b0);
    run_op(2'b00, 8'h80, 8'h80, 1'b1, 8'h01, 1'b1, 1'b0);
    run_op(2'b00, 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b1);

    // Abort an operation with reset after 4 RUN cycles
    @(negedge clk);
    op = 2'b11; a = 8'h33; b = 8'h11; cin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_result", result, 0);
    chk("abort_cout", cout, 0);
    chk("abort_zero", zero, 0);
    chk("abort_slice", {slice_a, slice_b, slice_cin, slice_ctrl}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    last_cout = 1'b0;
    run_op(2'b00, 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0);

    repeat (5) @(negedge clk);
    chk("done_count", n_done, n_expect);
    chk("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
